spi_slave_regs: RTL and testbench

- SPI slave register bank. It sits directly downstream of the team's SPI master on the same SCK/SSB/MOSI/MISO wires and consumes its two-byte transactions: a command byte followed by a data byte.
- It decodes the command, writes or reads an internal 8-bit register file, and returns read data on MISO during the data byte.
- It exports a one-cycle write strobe so that downstream logic can react to register updates.

---
 rtl/spi_slave_regs.sv | 112 +++++++++++
 tb/tb_spi_slave_regs.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI slave register bank decoding command/data byte pairs on SCK
module spi_slave_regs #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] DEVICE_ID = 8'hA5
) (
    input  logic              SCK,
    input  logic              reset,
    input  logic              SSB,
    input  logic              MOSI,
    output logic              MISO,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err
);

    localparam int           N_REGS   = 2 ** ADDR_W;
    localparam logic [1:0]   ST_CMD   = 2'd0;
    localparam logic [1:0]   ST_WDATA = 2'd1;
    localparam logic [1:0]   ST_RDATA = 2'd2;

    logic [1:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_sr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_frame_err;
    // Entry 0 is never written; register 0 always reads DEVICE_ID.
    logic [DATA_W-1:0] r_regs [0:N_REGS-1];

    logic [DATA_W-1:0] w_byte;
    logic              w_byte_done;
    logic              w_abort;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_cmd_read;
    logic [DATA_W-1:0] w_rd_data;

    assign w_byte      = {r_sr[DATA_W-2:0], MOSI};
    assign w_byte_done = !SSB && (r_bit_cnt == 3'd7);
    assign w_abort     = SSB && (r_bit_cnt != 3'd0);
    assign w_cmd_addr  = w_byte[ADDR_W-1:0];
    assign w_cmd_read  = w_byte[DATA_W-1];
    assign w_rd_data   = (w_cmd_addr == '0) ? DEVICE_ID : r_regs[w_cmd_addr];

    assign MISO      = r_sr[DATA_W-1];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;

    always_ff @(posedge SCK) begin
        if (!reset) begin
            r_state     <= ST_CMD;
            r_bit_cnt   <= 3'd0;
            r_sr        <= '0;
            r_addr      <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (!SSB) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD: begin
                            r_addr <= w_cmd_addr;
                            if (w_cmd_read) begin
                                // Preload so MISO carries the read MSB before the data byte starts.
                                r_sr    <= w_rd_data;
                                r_state <= ST_RDATA;
                            end else begin
                                r_sr    <= '0;
                                r_state <= ST_WDATA;
                            end
                        end
                        ST_WDATA: begin
                            if (r_addr != '0) begin
                                r_regs[r_addr] <= w_byte;
                                r_wr_addr      <= r_addr;
                                r_wr_data      <= w_byte;
                                r_wr_strobe    <= 1'b1;
                            end
                            r_sr    <= '0;
                            r_state <= ST_CMD;
                        end
                        default: begin
                            r_sr    <= '0;
                            r_state <= ST_CMD;
                        end
                    endcase
                end else begin
                    r_sr <= w_byte;
                end
            end else if (w_abort) begin
                r_bit_cnt   <= 3'd0;
                r_sr        <= '0;
                r_state     <= ST_CMD;
                r_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - directed self-checking bench for spi_slave_regs
module tb_spi_slave_regs;

    logic       SCK = 1'b0;
    logic       reset = 1'b0;
    logic       SSB = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    int         strobe_cnt = 0;
    int         ferr_cnt   = 0;
    int         both_cnt   = 0;
    logic [7:0] cap_addr   = 8'h00;
    logic [7:0] cap_data   = 8'h00;

    spi_slave_regs #(.ADDR_W(4), .DATA_W(8), .DEVICE_ID(8'hA5)) dut (
        .SCK       (SCK),
        .reset     (reset),
        .SSB       (SSB),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 SCK = ~SCK;

    always @(negedge SCK) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            cap_addr   = {4'h0, wr_addr};
            cap_data   = wr_data;
        end
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (wr_strobe === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Master behaviour: MISO sampled and MOSI driven together ahead of each posedge.
    task automatic send_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge SCK);
            SSB   = 1'b0;
            MOSI  = tx[i];
            rx[i] = MISO;
            @(posedge SCK);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge SCK);
            SSB  = 1'b1;
            MOSI = 1'b0;
            @(posedge SCK);
        end
    endtask

    task automatic txn(input logic [7:0] cmd, input logic [7:0] dat,
                       output logic [7:0] rx_cmd, output logic [7:0] rx_dat);
        send_bits(cmd, 8, rx_cmd);
        send_bits(dat, 8, rx_dat);
        idle(1);
    endtask

    initial begin
        logic [7:0] rc;
        logic [7:0] rd;
        int         s0;
        int         f0;

        reset = 1'b0;
        repeat (3) @(posedge SCK);
        @(negedge SCK);
        chk("rst_miso", {7'h0, MISO}, 8'h00);
        chk("rst_strobe", {7'h0, wr_strobe}, 8'h00);
        chk("rst_ferr", {7'h0, frame_err}, 8'h00);
        chk("rst_wr_addr", {4'h0, wr_addr}, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        reset = 1'b1;
        idle(2);

        s0 = strobe_cnt;
        txn(8'h01, 8'h22, rc, rd);
        chk("wr1_rx_cmd", rc, 8'h00);
        chk("wr1_rx_dat", rd, 8'h00);
        chk("wr1_strobes", 8'(strobe_cnt - s0), 8'd1);
        chk("wr1_addr", cap_addr, 8'h01);
        chk("wr1_data", cap_data, 8'h22);

        s0 = strobe_cnt;
        txn(8'h81, 8'h00, rc, rd);
        chk("rd1_rx_cmd", rc, 8'h00);
        chk("rd1_rx_dat", rd, 8'h22);
        chk("rd1_strobes", 8'(strobe_cnt - s0), 8'd0);

        txn(8'h80, 8'h00, rc, rd);
        chk("id_rd", rd, 8'hA5);
        s0 = strobe_cnt;
        txn(8'h00, 8'h55, rc, rd);
        chk("id_wr_strobes", 8'(strobe_cnt - s0), 8'd0);
        txn(8'h80, 8'h00, rc, rd);
        chk("id_rd_again", rd, 8'hA5);

        f0 = ferr_cnt;
        s0 = strobe_cnt;
        send_bits(8'h83, 5, rc);
        idle(3);
        chk("abort_ferr", 8'(ferr_cnt - f0), 8'd1);
        chk("abort_strobes", 8'(strobe_cnt - s0), 8'd0);
        s0 = strobe_cnt;
        txn(8'h03, 8'h3C, rc, rd);
        chk("wr3_strobes", 8'(strobe_cnt - s0), 8'd1);
        chk("wr3_addr", cap_addr, 8'h03);
        chk("wr3_data", cap_data, 8'h3C);

        s0 = strobe_cnt;
        f0 = ferr_cnt;
        send_bits(8'h05, 8, rc);
        send_bits(8'h77, 4, rd);
        @(negedge SCK);
        reset = 1'b0;
        SSB   = 1'b1;
        @(posedge SCK);
        #1;
        chk("rst_mid_miso", {7'h0, MISO}, 8'h00);
        @(negedge SCK);
        reset = 1'b1;
        idle(2);
        chk("rst_mid_strobes", 8'(strobe_cnt - s0), 8'd0);
        chk("rst_mid_ferr", 8'(ferr_cnt - f0), 8'd0);
        txn(8'h85, 8'h00, rc, rd);
        chk("rst_rd5", rd, 8'h00);
        txn(8'h81, 8'h00, rc, rd);
        chk("rst_rd1_cleared", rd, 8'h00);
        txn(8'h05, 8'h77, rc, rd);
        txn(8'h85, 8'h00, rc, rd);
        chk("rd5_after_wr", rd, 8'h77);

        s0 = strobe_cnt;
        txn(8'h0F, 8'hFF, rc, rd);
        chk("b2b_a_strobes", 8'(strobe_cnt - s0), 8'd1);
        chk("b2b_a_addr", cap_addr, 8'h0F);
        chk("b2b_a_data", cap_data, 8'hFF);
        txn(8'h0E, 8'h80, rc, rd);
        chk("b2b_b_strobes", 8'(strobe_cnt - s0), 8'd2);
        chk("b2b_b_addr", cap_addr, 8'h0E);
        chk("b2b_b_data", cap_data, 8'h80);
        txn(8'h8F, 8'h00, rc, rd);
        chk("rd_f", rd, 8'hFF);
        txn(8'h8E, 8'h00, rc, rd);
        chk("rd_e", rd, 8'h80);

        chk("strobe_ferr_overlap", 8'(both_cnt), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
